// File: rtl/ps2_ascii2scan.sv
// ps2_ascii2scan: turns one ASCII character into the PS/2 set-2 make/break
// byte sequence a US-layout keyboard would send (caps lock off), emitted one
// byte per strobe with a configurable idle gap between bytes.
// Optional feature: define PS2_ASCII2SCAN_EXT_EN to map bytes with bit 7 set
// onto E0-prefixed extended-key sequences; otherwise those bytes are dropped.
module ps2_ascii2scan #(
    parameter int GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ascii_code_new,
    input  logic [7:0] ascii_code,
    input  logic       ps2_tx_busy,
    output logic       ps2_code_new,
    output logic [7:0] ps2_code,
    output logic       busy,
    output logic       ascii_drop
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT, S_GAP} state_t;
    typedef enum logic [1:0] {C_NONE, C_PLAIN, C_SHIFT, C_EXT} cls_t;

    state_t          state, state_next;
    cls_t            cls_q, lk_cls;
    logic            new_q;
    logic [7:0]      char_q;
    logic [7:0]      code_q;
    logic [7:0]      lk_code;
    logic [9:0]      lk;
    logic [2:0]      idx;
    logic [2:0]      last_idx;
    logic [CW-1:0]   cnt;
    logic [7:0]      hold_q;
    logic [7:0]      cur_byte;
    logic            drop_q;
    logic            edge_det;
    logic            accept;
    logic            strobe;
    logic            gap_done;

    // Set-2 make codes for a..z, indexed by letter offset.
    function automatic logic [7:0] letter_code(input logic [4:0] i);
        logic [7:0] r;
        case (i)
            5'd0:  r = 8'h1C;  5'd1:  r = 8'h32;  5'd2:  r = 8'h21;
            5'd3:  r = 8'h23;  5'd4:  r = 8'h24;  5'd5:  r = 8'h2B;
            5'd6:  r = 8'h34;  5'd7:  r = 8'h33;  5'd8:  r = 8'h43;
            5'd9:  r = 8'h3B;  5'd10: r = 8'h42;  5'd11: r = 8'h4B;
            5'd12: r = 8'h3A;  5'd13: r = 8'h31;  5'd14: r = 8'h44;
            5'd15: r = 8'h4D;  5'd16: r = 8'h15;  5'd17: r = 8'h2D;
            5'd18: r = 8'h1B;  5'd19: r = 8'h2C;  5'd20: r = 8'h3C;
            5'd21: r = 8'h2A;  5'd22: r = 8'h1D;  5'd23: r = 8'h22;
            5'd24: r = 8'h35;  5'd25: r = 8'h1A;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Set-2 make codes for the digit row 0..9.
    function automatic logic [7:0] digit_code(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd0: r = 8'h45;  4'd1: r = 8'h16;  4'd2: r = 8'h1E;
            4'd3: r = 8'h26;  4'd4: r = 8'h25;  4'd5: r = 8'h2E;
            4'd6: r = 8'h36;  4'd7: r = 8'h3D;  4'd8: r = 8'h3E;
            4'd9: r = 8'h46;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Full character map: returns {class, make code}.
    function automatic logic [9:0] lookup(input logic [7:0] c);
        logic [9:0] r;
        logic [7:0] off;
        r = {C_NONE, 8'h00};
        off = 8'h00;
        if (c >= 8'h61 && c <= 8'h7A) begin
            off = c - 8'h61;
            r = {C_PLAIN, letter_code(off[4:0])};
        end else if (c >= 8'h41 && c <= 8'h5A) begin
            off = c - 8'h41;
            r = {C_SHIFT, letter_code(off[4:0])};
        end else if (c >= 8'h30 && c <= 8'h39) begin
            off = c - 8'h30;
            r = {C_PLAIN, digit_code(off[3:0])};
        end else begin
            case (c)
                8'h1B: r = {C_PLAIN, 8'h76};  // ESC
                8'h08: r = {C_PLAIN, 8'h66};  // backspace
                8'h0D: r = {C_PLAIN, 8'h5A};  // enter
                8'h20: r = {C_PLAIN, 8'h29};  // space
                8'h27: r = {C_PLAIN, 8'h52};  // '
                8'h2C: r = {C_PLAIN, 8'h41};  // ,
                8'h2D: r = {C_PLAIN, 8'h4E};  // -
                8'h2E: r = {C_PLAIN, 8'h49};  // .
                8'h2F: r = {C_PLAIN, 8'h4A};  // /
                8'h3B: r = {C_PLAIN, 8'h4C};  // ;
                8'h3D: r = {C_PLAIN, 8'h55};  // =
                8'h5B: r = {C_PLAIN, 8'h54};  // [
                8'h5C: r = {C_PLAIN, 8'h5D};  // backslash
                8'h5D: r = {C_PLAIN, 8'h5B};  // ]
                8'h60: r = {C_PLAIN, 8'h0E};  // `
                8'h21: r = {C_SHIFT, 8'h16};  // !
                8'h22: r = {C_SHIFT, 8'h52};  // "
                8'h23: r = {C_SHIFT, 8'h26};  // #
                8'h24: r = {C_SHIFT, 8'h25};  // $
                8'h25: r = {C_SHIFT, 8'h2E};  // %
                8'h26: r = {C_SHIFT, 8'h3D};  // &
                8'h28: r = {C_SHIFT, 8'h46};  // (
                8'h29: r = {C_SHIFT, 8'h45};  // )
                8'h2A: r = {C_SHIFT, 8'h3E};  // *
                8'h2B: r = {C_SHIFT, 8'h55};  // +
                8'h3A: r = {C_SHIFT, 8'h4C};  // :
                8'h3C: r = {C_SHIFT, 8'h41};  // <
                8'h3E: r = {C_SHIFT, 8'h49};  // >
                8'h3F: r = {C_SHIFT, 8'h4A};  // ?
                8'h40: r = {C_SHIFT, 8'h1E};  // @
                8'h5E: r = {C_SHIFT, 8'h36};  // ^
                8'h5F: r = {C_SHIFT, 8'h4E};  // _
                8'h7B: r = {C_SHIFT, 8'h54};  // {
                8'h7C: r = {C_SHIFT, 8'h5D};  // |
                8'h7D: r = {C_SHIFT, 8'h5B};  // }
                8'h7E: r = {C_SHIFT, 8'h0E};  // ~
                default: r = {C_NONE, 8'h00};
            endcase
`ifdef PS2_ASCII2SCAN_EXT_EN
            if (c[7]) r = {C_EXT, 1'b0, c[6:0]};
`endif
        end
        return r;
    endfunction

    // Request edge detection, gating and strobe qualification.
    always_comb begin
        lk       = lookup(char_q);
        lk_cls   = cls_t'(lk[9:8]);
        lk_code  = lk[7:0];
        edge_det = ascii_code_new & ~new_q;
        accept   = edge_det & (state == S_IDLE);
        strobe   = (state == S_EMIT) & ~ps2_tx_busy & ~rst;
        gap_done = (state == S_GAP) && (int'(cnt) >= GAP - 1);
    end

    // Byte to emit at the current position and the position of the last byte.
    always_comb begin
        cur_byte = 8'h00;
        last_idx = 3'd0;
        case (cls_q)
            C_PLAIN: begin
                last_idx = 3'd2;
                cur_byte = (idx == 3'd1) ? 8'hF0 : code_q;
            end
            C_SHIFT: begin
                last_idx = 3'd5;
                case (idx)
                    3'd0, 3'd5: cur_byte = 8'h12;
                    3'd1, 3'd3: cur_byte = code_q;
                    default:    cur_byte = 8'hF0;
                endcase
            end
`ifdef PS2_ASCII2SCAN_EXT_EN
            C_EXT: begin
                last_idx = 3'd4;
                case (idx)
                    3'd0, 3'd2: cur_byte = 8'hE0;
                    3'd1, 3'd4: cur_byte = code_q;
                    default:    cur_byte = 8'hF0;
                endcase
            end
`endif
            default: begin
                last_idx = 3'd0;
                cur_byte = 8'h00;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_LOOKUP;
            S_LOOKUP: state_next = (lk_cls == C_NONE) ? S_IDLE : S_EMIT;
            S_EMIT:   if (!ps2_tx_busy) state_next = S_GAP;
            S_GAP:    if (gap_done) state_next = (idx == last_idx) ? S_IDLE : S_EMIT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: latched character, lookup result, byte position, gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            new_q  <= 1'b1;
            char_q <= 8'h00;
            code_q <= 8'h00;
            cls_q  <= C_NONE;
            idx    <= 3'd0;
            cnt    <= '0;
            hold_q <= 8'h00;
            drop_q <= 1'b0;
        end else begin
            new_q  <= ascii_code_new;
            drop_q <= (state == S_LOOKUP) && (lk_cls == C_NONE);
            cnt    <= ((state == S_GAP) && !gap_done) ? cnt + CW'(1) : '0;
            if (accept) char_q <= ascii_code;
            if (state == S_LOOKUP) begin
                code_q <= lk_code;
                cls_q  <= lk_cls;
                idx    <= 3'd0;
            end
            if (strobe) hold_q <= cur_byte;
            if (gap_done && idx != last_idx) idx <= idx + 3'd1;
        end
    end

    // Outputs: strobe and byte are live in the EMIT cycle, byte holds afterwards.
    always_comb begin
        ps2_code_new = strobe;
        ps2_code     = strobe ? cur_byte : hold_q;
        busy         = (state != S_IDLE);
        ascii_drop   = drop_q | (edge_det & (state != S_IDLE) & ~rst);
    end

endmodule
